// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4
// Scans a 4x4 active-low matrix keypad one column at a time, classifies each
// complete four-column scan as NONE or a single KEY, debounces whole scans and
// emits one key_valid pulse per accepted press.
//
// Handshake: key_valid is a one-clk strobe with no ready/back-pressure; key_code
// is valid in the same cycle as key_valid and holds until the next accepted press.
// key_held tracks the debounced pressed state.  fsm_state exposes the press FSM
// (0 = RELEASED, 1 = PRESSED) for observation.
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV_W     = 13,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       fsm_state
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    // Prescaler and scan tick
    logic [SCAN_DIV_W-1:0] presc_q;
    logic                  tick;

    // Row synchronizer
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    // Column walk and scan accumulator; acc_cnt_q saturates at 2 meaning "many"
    logic [1:0] col_idx_q;
    logic [1:0] acc_cnt_q;
    logic [3:0] acc_key_q;

    // Debounce history
    logic       prev_valid_q;
    logic [3:0] prev_key_q;
    logic [3:0] stable_q;

    // Combinational scan evaluation
    logic [3:0] col_lows;
    logic [2:0] col_n;
    logic [1:0] col_row;
    logic [2:0] acc_sum;
    logic [1:0] acc_cnt_new;
    logic [3:0] acc_key_new;
    logic       res_valid;
    logic [3:0] res_key;
    logic       same;
    logic [3:0] stable_new;
    logic       scan_done;

    // FSM
    state_t state_q;
    state_t state_d;
    logic   press_evt;
    logic   release_evt;

    // The tick strobes in the cycle where the prescaler sits at all-ones,
    // so the sampling edge is exactly the wrap edge.
    assign tick      = &presc_q;
    assign fsm_state = state_q;

    // Free-running prescaler
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous, pulled-up row lines
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Classify the currently driven column and fold it into the scan result
    always_comb begin
        col_lows = ~row_sync;
        col_n    = {2'b00, col_lows[0]} + {2'b00, col_lows[1]}
                 + {2'b00, col_lows[2]} + {2'b00, col_lows[3]};
        col_row  = 2'd0;
        if (col_lows[3]) col_row = 2'd3;
        if (col_lows[2]) col_row = 2'd2;
        if (col_lows[1]) col_row = 2'd1;
        if (col_lows[0]) col_row = 2'd0;

        acc_sum     = {1'b0, acc_cnt_q} + col_n;
        acc_cnt_new = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        acc_key_new = acc_key_q;
        if ((acc_cnt_q == 2'd0) && (col_n == 3'd1)) begin
            acc_key_new = {col_row, col_idx_q};
        end

        // Exactly one low row bit over the whole scan is a KEY; anything else is NONE
        res_valid = (acc_cnt_new == 2'd1);
        res_key   = acc_key_new;

        same = (res_valid == prev_valid_q) && (!res_valid || (res_key == prev_key_q));
        if (same) begin
            stable_new = (stable_q >= DB) ? DB : (stable_q + 4'd1);
        end else begin
            stable_new = 4'd1;
        end

        scan_done = tick && (col_idx_q == 2'd3);
    end

    // Column drive, accumulator and debounce history; all advance on tick only
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            col          <= 4'b1110;
            col_idx_q    <= 2'd0;
            acc_cnt_q    <= 2'd0;
            acc_key_q    <= 4'd0;
            prev_valid_q <= 1'b0;
            prev_key_q   <= 4'd0;
            stable_q     <= 4'd0;
        end else if (tick) begin
            col       <= {col[2:0], col[3]};
            col_idx_q <= col_idx_q + 2'd1;
            if (scan_done) begin
                acc_cnt_q    <= 2'd0;
                acc_key_q    <= 4'd0;
                prev_valid_q <= res_valid;
                prev_key_q   <= res_valid ? res_key : 4'd0;
                stable_q     <= stable_new;
            end else begin
                acc_cnt_q <= acc_cnt_new;
                acc_key_q <= acc_key_new;
            end
        end
    end

    // Press FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    // Press FSM next state: decisions are taken only when a scan completes
    always_comb begin
        state_d     = state_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        if (scan_done) begin
            case (state_q)
                RELEASED: begin
                    if (res_valid && (stable_new == DB)) begin
                        state_d   = PRESSED;
                        press_evt = 1'b1;
                    end
                end
                PRESSED: begin
                    // A different stable key while pressed is ignored until a
                    // debounced release has been seen.
                    if (!res_valid && (stable_new == DB)) begin
                        state_d     = RELEASED;
                        release_evt = 1'b1;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    // Registered key outputs; key_code survives release
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= press_evt;
            if (press_evt) begin
                key_code <= res_key;
                key_held <= 1'b1;
            end else if (release_evt) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4
// Drives a modelled 4x4 keypad against keypad_scanner_4x4 with a 4-clk scan tick
// (16-clk scans) and a 4-scan debounce.
module tb_keypad_scanner_4x4;

    // Clock / reset
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       fsm_state;

    always #5 clk = ~clk;

    keypad_scanner_4x4 #(
        .SCAN_DIV_W    (2),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .fsm_state(fsm_state)
    );

    // Keypad model: key k = row*4+col pulls its row low while its column is driven low
    logic [15:0] keys_drv = 16'h0000;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_drv[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    // Clocks since reset release
    int cyc;
    always @(posedge clk or posedge clr) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard
    logic [19:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int scan_no  = 0;
    logic last_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          nscans;
        int          pulse_at;   // scan within the step that completes the press, 0 = none
        logic [3:0]  code;       // key_code after the step (and of the pulse)
        logic        held;       // key_held after the step
    } step_t;

    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K10 = 16'h0400;
    localparam logic [15:0] KMULTI = 16'h8001;

    step_t steps[15];

    task automatic run_step(input step_t s, input int idx);
        string tag;
        tag = $sformatf("step%0d", idx);
        keys_drv = s.keys;
        if (s.pulse_at != 0) begin
            exp_q.push_back({16'((scan_no + s.pulse_at) * 16), s.code});
        end
        repeat (s.nscans * 16) @(negedge clk);
        scan_no += s.nscans;
        #1;
        check({tag, "_pending_pulse"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_key_held"}, key_held, s.held);
        check({tag, "_fsm_state"}, fsm_state, s.held);
        check({tag, "_key_code"}, key_code, s.code);
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;

        //             keys    scans pulse code   held
        steps[0]  = '{16'h0,   2,    0,    4'd0,  1'b0};  // column walk, no keys
        steps[1]  = '{K6,      6,    4,    4'd6,  1'b1};  // clean press
        steps[2]  = '{16'h0,   4,    0,    4'd6,  1'b0};  // debounced release
        steps[3]  = '{K6,      1,    0,    4'd6,  1'b0};  // bounce
        steps[4]  = '{16'h0,   1,    0,    4'd6,  1'b0};
        steps[5]  = '{K6,      1,    0,    4'd6,  1'b0};
        steps[6]  = '{16'h0,   1,    0,    4'd6,  1'b0};
        steps[7]  = '{K6,      5,    4,    4'd6,  1'b1};  // settles
        steps[8]  = '{16'h0,   4,    0,    4'd6,  1'b0};
        steps[9]  = '{KMULTI,  8,    0,    4'd6,  1'b0};  // multi-press ignored
        steps[10] = '{K5,      4,    4,    4'd5,  1'b1};
        steps[11] = '{K10,     4,    0,    4'd5,  1'b1};  // roll-over, no event
        steps[12] = '{16'h0,   4,    0,    4'd5,  1'b0};
        steps[13] = '{K10,     4,    4,    4'd10, 1'b1};
        steps[14] = '{16'h0,   4,    0,    4'd10, 1'b0};

        // Monitor: column walk every cycle, pulses against the expected queue
        fork
            forever begin
                logic [3:0] exp_col;
                logic [19:0] e;
                @(negedge clk);
                exp_col = ~(one << ((cyc >> 2) & 3));
                check("col", col, exp_col);
                if (key_valid) begin
                    check("valid_back_to_back", last_valid, 1'b0);
                    check("held_with_valid", key_held, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse_code", key_code, 4'hX);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_cycle_code", {16'(cyc), key_code}, e);
                    end
                end
                last_valid = key_valid;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_key_code", key_code, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_fsm_state", fsm_state, 1'b0);
        clr = 1'b0;
        scan_no = 0;

        for (int i = 0; i < 15; i++) begin
            run_step(steps[i], i);
        end

        // Reset in the middle of a debounce, key stays down across it
        keys_drv = K3;
        repeat (2 * 16 + 6) @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("midrst_col", col, 4'b1110);
        check("midrst_key_code", key_code, 4'd0);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_held", key_held, 1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        scan_no = 0;
        exp_q.push_back({16'(4 * 16), 4'd3});
        repeat (3 * 16) @(negedge clk);
        #1;
        check("midrst_no_early_pulse", exp_q.size(), 1);
        repeat (16) @(negedge clk);
        #1;
        check("midrst_pending_pulse", exp_q.size(), 0);
        exp_q.delete();
        check("midrst_key_held_after", key_held, 1'b1);
        check("midrst_key_code_after", key_code, 4'd3);

        keys_drv = 16'h0;
        repeat (4 * 16) @(negedge clk);
        #1;
        check("final_key_held", key_held, 1'b0);
        check("final_key_code", key_code, 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
